mem_arbiter: RTL and testbench

Arbitrates the single-port 16-bit unified memory between two masters:
- the multicycle CPU, driven by the controller's MemRead/MemWrite/IRWrite phases;
- the program loader/debug port.

It serializes accesses, registers the winning request onto the memory port, sequences the fixed read latency, and returns read data with a valid strobe. It also drives a stall to the controller so the FSM holds its current state until its access has completed.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU memory subsystem:
// arbiter state encoding, master ids and the bus widths used by the
// controller, datapath and memory arbiter.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Master ids; also index the request vector fed to the round-robin picker
  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  // Latency counter width covers read latencies 1..3
  localparam int LAT_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

  // Counter value loaded in ACCESS so that rvalid lands on the last WAIT cycle
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
    return LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters (CPU, loader), the arbiter and the
// single-port memory. slave = arbiter view, master = masters + memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_stall,
    output ldr_gnt, ldr_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_stall,
    input  ldr_gnt, ldr_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector. A lone requester wins; on a tie the master
// that was not granted last wins. Output is a master id (M_CPU / M_LDR).
module rr_pick2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_sel
);

  // Winner select; with no request the value is ignored by the arbiter
  always_comb begin
    gnt_sel = M_CPU;
    case (req)
      2'b01:   gnt_sel = M_CPU;
      2'b10:   gnt_sel = M_LDR;
      2'b11:   gnt_sel = ~last;
      default: gnt_sel = M_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between the multicycle CPU and the program loader for the
// single-port unified memory. One access in flight at a time; reads return
// MEM_LAT cycles after the memory strobe.
// Build option MEM_ARB_LDR_PRIO_EN: loader wins every tie (no round-robin).
//
// state  | meaning
// IDLE   | sample requests, latch winner's access
// ACCESS | memory strobe issued, winner granted
// WAIT   | counting read latency, rvalid on last cycle
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_t           state;
  logic                 win_q;
  logic                 we_q;
  logic [LAT_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 mem_en_q;
  logic                 mem_we_q;
  logic                 cpu_gnt_q;
  logic                 ldr_gnt_q;
  logic                 cpu_rvalid_q;
  logic                 ldr_rvalid_q;
  logic                 pick;

`ifdef MEM_ARB_LDR_PRIO_EN
  assign pick = bus.ldr_req ? M_LDR : M_CPU;
`else
  logic last_gnt;

  rr_pick2 u_pick (
    .req     ({bus.ldr_req, bus.cpu_req}),
    .last    (last_gnt),
    .gnt_sel (pick)
  );
`endif

  // Arbitration FSM; all strobes are registered and pulse for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      win_q        <= M_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
`ifndef MEM_ARB_LDR_PRIO_EN
      last_gnt     <= M_LDR;
`endif
    end else begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req | bus.ldr_req) begin
            win_q    <= pick;
            mem_en_q <= 1'b1;
            state    <= ACCESS;
            if (pick == M_LDR) begin
              we_q      <= bus.ldr_we;
              mem_we_q  <= bus.ldr_we;
              addr_q    <= bus.ldr_addr;
              wdata_q   <= bus.ldr_wdata;
              ldr_gnt_q <= 1'b1;
            end else begin
              we_q      <= bus.cpu_we;
              mem_we_q  <= bus.cpu_we;
              addr_q    <= bus.cpu_addr;
              wdata_q   <= bus.cpu_wdata;
              cpu_gnt_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
`ifndef MEM_ARB_LDR_PRIO_EN
          last_gnt <= win_q;
`endif
          if (we_q) begin
            state <= IDLE;
          end else begin
            cnt   <= lat_load(MEM_LAT);
            state <= WAIT;
            // Single-cycle latency: the first WAIT cycle is already the data cycle
            if (MEM_LAT == 1) begin
              cpu_rvalid_q <= (win_q == M_CPU);
              ldr_rvalid_q <= (win_q == M_LDR);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == LAT_CNT_W'(1)) begin
              cpu_rvalid_q <= (win_q == M_CPU);
              ldr_rvalid_q <= (win_q == M_LDR);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Keep the last returned word so rdata is stable between rvalid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (cpu_rvalid_q | ldr_rvalid_q) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // Memory data is only valid in the rvalid cycle, so it is passed through then
  assign bus.rdata      = (cpu_rvalid_q | ldr_rvalid_q) ? bus.mem_rdata : rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.ldr_gnt    = ldr_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.cpu_stall  = bus.cpu_req & ~(cpu_gnt_q & bus.cpu_we) & ~cpu_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with read latency 1, 2, 3,
// each with a small memory model, and a scoreboard of expected grants/reads.
module tb_mem_arbiter;
  import cpu_pkg::*;

`ifdef MEM_ARB_LDR_PRIO_EN
  localparam bit LDR_PRIO = 1'b1;
`else
  localparam bit LDR_PRIO = 1'b0;
`endif

  typedef struct packed {
    logic        m;
    logic [15:0] d;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int ng;
  int nr;
  rd_exp_t exp_rd[$];
  logic    exp_gnt[$];

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus2 ();
  mem_arbiter_if bus3 ();

  mem_arbiter #(.MEM_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_arbiter #(.MEM_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus2));
  mem_arbiter #(.MEM_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory models: read data appears MEM_LAT cycles after the strobe cycle
  logic        v1;
  logic [1:0]  v2;
  logic [2:0]  v3;
  logic [15:0] d1;
  logic [15:0] d2 [2];
  logic [15:0] d3 [3];

  always @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= '0;
      v3 <= '0;
    end else begin
      v1 <= bus1.mem_en & ~bus1.mem_we;
      v2 <= {v2[0], bus2.mem_en & ~bus2.mem_we};
      v3 <= {v3[1:0], bus3.mem_en & ~bus3.mem_we};
    end
    d1    <= mem_fn(bus1.mem_addr);
    d2[0] <= mem_fn(bus2.mem_addr);
    d2[1] <= d2[0];
    d3[0] <= mem_fn(bus3.mem_addr);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  assign bus1.mem_rdata = v1    ? d1    : 16'hDEAD;
  assign bus2.mem_rdata = v2[1] ? d2[1] : 16'hDEAD;
  assign bus3.mem_rdata = v3[2] ? d3[2] : 16'hDEAD;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rd_exp_t e;
    logic    m;
    logic    has_c;
    logic    has_l;
    logic    seen;

    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.ldr_req = 0; bus1.ldr_we = 0; bus1.ldr_addr = '0; bus1.ldr_wdata = '0;
    bus2.cpu_req = 0; bus2.cpu_we = 0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    bus2.ldr_req = 0; bus2.ldr_we = 0; bus2.ldr_addr = '0; bus2.ldr_wdata = '0;
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.ldr_req = 0; bus3.ldr_we = 0; bus3.ldr_addr = '0; bus3.ldr_wdata = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    settle();
    chk("rst_ctl_b1", {bus1.cpu_gnt, bus1.ldr_gnt, bus1.cpu_rvalid, bus1.ldr_rvalid, bus1.mem_en, bus1.mem_we, bus1.cpu_stall}, 0);
    chk("rst_bus_b1", {bus1.mem_addr, bus1.mem_wdata}, 0);
    chk("rst_rdata_b1", bus1.rdata, 0);
    chk("rst_ctl_b2", {bus2.cpu_gnt, bus2.ldr_gnt, bus2.cpu_rvalid, bus2.ldr_rvalid, bus2.mem_en, bus2.mem_we, bus2.cpu_stall}, 0);
    chk("rst_bus_b2", {bus2.mem_addr, bus2.mem_wdata}, 0);
    chk("rst_ctl_b3", {bus3.cpu_gnt, bus3.ldr_gnt, bus3.cpu_rvalid, bus3.ldr_rvalid, bus3.mem_en, bus3.mem_we, bus3.cpu_stall}, 0);
    chk("rst_bus_b3", {bus3.mem_addr, bus3.mem_wdata}, 0);

    // CPU read, latency 1, address 0x0010
    cyc();
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h0010;
    exp_rd.push_back('{m: M_CPU, d: 16'hBEEF});
    settle();
    chk("b1_rd_stall_c0", bus1.cpu_stall, 1);
    cyc();
    chk("b1_rd_gnt_c1", {bus1.cpu_gnt, bus1.ldr_gnt, bus1.mem_en, bus1.mem_we}, 4'b1010);
    chk("b1_rd_addr_c1", bus1.mem_addr, 16'h0010);
    chk("b1_rd_stall_c1", bus1.cpu_stall, 1);
    cyc();
    e = exp_rd.pop_front();
    chk("b1_rd_rvalid_c2", {bus1.cpu_rvalid, bus1.ldr_rvalid}, 2'b10);
    chk("b1_rd_rdata_c2", bus1.rdata, e.d);
    chk("b1_rd_stall_c2", bus1.cpu_stall, 0);
    cyc();
    bus1.cpu_req = 0;
    settle();
    chk("b1_rd_hold_c3", {bus1.cpu_rvalid, bus1.rdata}, {1'b0, 16'hBEEF});

    // CPU write: stall drops in the grant cycle
    cyc();
    bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 16'h0055; bus1.cpu_wdata = 16'hA0A0;
    settle();
    chk("b1_wr_stall_c0", bus1.cpu_stall, 1);
    cyc();
    chk("b1_wr_gnt_c1", {bus1.cpu_gnt, bus1.mem_en, bus1.mem_we, bus1.cpu_stall}, 4'b1110);
    chk("b1_wr_bus_c1", {bus1.mem_addr, bus1.mem_wdata}, {16'h0055, 16'hA0A0});
    bus1.cpu_req = 0; bus1.cpu_we = 0;

    // Loader write, never returns rvalid
    cyc();
    cyc();
    bus1.ldr_req = 1; bus1.ldr_we = 1; bus1.ldr_addr = 16'h0100; bus1.ldr_wdata = 16'h1234;
    cyc();
    chk("b1_ldw_gnt_c1", {bus1.ldr_gnt, bus1.cpu_gnt, bus1.mem_en, bus1.mem_we}, 4'b1011);
    chk("b1_ldw_bus_c1", {bus1.mem_addr, bus1.mem_wdata}, {16'h0100, 16'h1234});
    bus1.ldr_req = 0; bus1.ldr_we = 0;
    seen = bus1.ldr_rvalid;
    for (int k = 0; k < 4; k++) begin
      cyc();
      seen = seen | bus1.ldr_rvalid;
    end
    chk("b1_ldw_no_rvalid", seen, 0);

    // Both masters reading continuously, latency 2
    for (int k = 0; k < 4; k++) begin
      if (LDR_PRIO) m = (k < 3) ? M_LDR : M_CPU;
      else          m = (k % 2 == 1) ? M_LDR : M_CPU;
      exp_gnt.push_back(m);
      exp_rd.push_back('{m: m, d: mem_fn((m == M_LDR) ? 16'h0040 : 16'h0020)});
    end
    cyc();
    bus2.cpu_req = 1; bus2.cpu_we = 0; bus2.cpu_addr = 16'h0020;
    bus2.ldr_req = 1; bus2.ldr_we = 0; bus2.ldr_addr = 16'h0040;
    ng = 0;
    nr = 0;
    for (int c = 1; c <= 40 && (ng < 4 || nr < 4); c++) begin
      cyc();
      if (bus2.cpu_gnt | bus2.ldr_gnt) begin
        if (exp_gnt.size() == 0) begin
          chk("b2_extra_gnt", {bus2.ldr_gnt, bus2.cpu_gnt}, 0);
        end else begin
          m = exp_gnt.pop_front();
          chk("b2_gnt_who", {bus2.ldr_gnt, bus2.cpu_gnt}, (m == M_LDR) ? 2'b10 : 2'b01);
          chk("b2_gnt_cycle", c, 1 + 4 * ng);
          chk("b2_gnt_addr", bus2.mem_addr, (m == M_LDR) ? 16'h0040 : 16'h0020);
          ng++;
          has_c = 1'b0;
          has_l = 1'b0;
          foreach (exp_gnt[i]) begin
            if (exp_gnt[i] == M_LDR) has_l = 1'b1;
            else                     has_c = 1'b1;
          end
          if (!has_c) bus2.cpu_req = 0;
          if (!has_l) bus2.ldr_req = 0;
        end
      end
      if (bus2.cpu_rvalid | bus2.ldr_rvalid) begin
        if (exp_rd.size() == 0) begin
          chk("b2_extra_rvalid", {bus2.ldr_rvalid, bus2.cpu_rvalid}, 0);
        end else begin
          e = exp_rd.pop_front();
          chk("b2_rvalid_who", {bus2.ldr_rvalid, bus2.cpu_rvalid}, (e.m == M_LDR) ? 2'b10 : 2'b01);
          chk("b2_rdata", bus2.rdata, e.d);
          chk("b2_rvalid_cycle", c, 3 + 4 * nr);
          nr++;
        end
      end
    end
    chk("b2_gnt_count", ng, 4);
    chk("b2_rvalid_count", nr, 4);
    bus2.cpu_req = 0;
    bus2.ldr_req = 0;

    // Reset during the WAIT phase of a latency-3 read
    cyc();
    bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 16'h0030;
    cyc();
    chk("b3_gnt_c1", {bus3.cpu_gnt, bus3.mem_en}, 2'b11);
    bus3.cpu_req = 0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus3.cpu_req = 1; bus3.cpu_addr = 16'h0033;
    bus3.ldr_req = 1; bus3.ldr_we = 0; bus3.ldr_addr = 16'h0077;
    m = LDR_PRIO ? M_LDR : M_CPU;
    exp_rd.push_back('{m: m, d: mem_fn((m == M_LDR) ? 16'h0077 : 16'h0033)});
    settle();
    chk("b3_rst_ctl", {bus3.cpu_gnt, bus3.ldr_gnt, bus3.cpu_rvalid, bus3.ldr_rvalid, bus3.mem_en, bus3.mem_we}, 0);
    chk("b3_rst_bus", {bus3.mem_addr, bus3.mem_wdata}, 0);
    chk("b3_rst_rdata", bus3.rdata, 0);
    cyc();
    chk("b3_tie_winner", {bus3.ldr_gnt, bus3.cpu_gnt}, (m == M_LDR) ? 2'b10 : 2'b01);
    chk("b3_no_stale_rvalid", {bus3.cpu_rvalid, bus3.ldr_rvalid}, 0);
    bus3.cpu_req = 0;
    bus3.ldr_req = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      cyc();
      if (bus3.cpu_rvalid | bus3.ldr_rvalid) begin
        seen = 1'b1;
        e = exp_rd.pop_front();
        chk("b3_rvalid_who", {bus3.ldr_rvalid, bus3.cpu_rvalid}, (e.m == M_LDR) ? 2'b10 : 2'b01);
        chk("b3_rdata", bus3.rdata, e.d);
        chk("b3_rvalid_latency", c, 3);
      end
    end
    chk("b3_rvalid_seen", seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
